pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
Central pipeline controller. It produces the stall[5:0] vector and the flush pulse consumed by every inter-stage register (pc, if_id, id_ex, ex_mem, mem_wb). It arbitrates stall requests from the IF, ID, EX and MEM stages and turns MEM-stage exceptions into a flush plus PC redirect. It holds a pending redirect while an instruction fetch is still in flight on the bus.

Parameters:
EXC_VECTOR, 32'h80000180, general exception entry address.
ERET_CODE, 32'h0000000e, excepttype value that marks ERET (redirect to EPC).

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
stallreq_if  in  1  fetch waiting on bus
stallreq_id  in  1  load-use / branch hazard
stallreq_ex  in  1  multi-cycle ALU (madd/msub/div) busy
stallreq_mem  in  1  data access waiting on bus
if_busy  in  1  instruction fetch transaction outstanding
mem_excepttype  in  32  exception type from MEM stage; nonzero = exception
cp0_epc  in  32  current EPC from CP0
stall  out  6  bit0 pc, 1 if, 2 id, 3 ex, 4 mem, 5 wb; 1 = stop
flush  out  1  clear all inter-stage registers this cycle
pc_redirect  out  1  pc register loads new_pc at next edge
new_pc  out  32  redirect target

Behaviour:
- FSM states: RUN, DRAIN. Reset -> RUN, pending_pc = 0.
- Reset outputs: stall = 6'b000000, flush = 0, pc_redirect = 0, new_pc = 0.
- stall, flush, pc_redirect and new_pc are combinational from inputs and state, so the pipeline registers sample them in the same cycle.
- RUN, mem_excepttype != 0 (exception wins over all stall requests):
  - flush = 1, stall = 0.
  - target = cp0_epc if mem_excepttype == ERET_CODE, else EXC_VECTOR; new_pc = target.
  - if_busy == 0: pc_redirect = 1; stay in RUN.
  - if_busy == 1: pc_redirect = 0; latch pending_pc = target; go to DRAIN.
- RUN, no exception: flush = 0, pc_redirect = 0, new_pc = 0.
  - stall is chosen by the highest requesting stage:
    - mem -> 6'b011111
    - else ex -> 6'b001111
    - else id -> 6'b000111
    - else if -> 6'b000011
    - else 6'b000000
- DRAIN:
  - flush = 0, new_pc = pending_pc.
  - if_busy == 1: stall = 6'b000011, pc_redirect = 0.
  - if_busy == 0: stall = 0, pc_redirect = 1; go to RUN at the next edge.
  - mem_excepttype and all stallreq_* inputs are ignored, since the pipeline holds only flushed bubbles. stallreq_if is covered by the 000011 hold.
- Simultaneous exception and stallreq_mem: the exception is taken and stall = 0. A faulting access issues no bus request.
- Exactly one flush per exception: the flush cycle is the cycle the exception is visible in RUN. DRAIN never re-flushes.
- Reset mid-DRAIN: returns to RUN, pending redirect discarded, outputs take reset values next cycle.
- Width: all PC values are 32-bit, with no arithmetic on them.

Optional Feature:
- Macro PIPE_CTRL_PERF_EN.
- When defined, two extra outputs:
  - stall_cycles, 32-bit: increments every cycle stall != 0.
  - flush_count, 32-bit: increments every cycle flush == 1.
  - Both wrap at 2^32 to 0 and are cleared by rst.
- When undefined, the ports and counters are absent and the rest of the behaviour is identical.

Test Plan:
- stallreq_id=1 and stallreq_ex=1 together, no exception -> stall=6'b001111, flush=0. Drop stallreq_ex -> stall=6'b000111.
- mem_excepttype=32'h00000008, if_busy=0 -> same cycle flush=1, stall=0, pc_redirect=1, new_pc=32'h80000180. Next cycle flush=0.
- mem_excepttype=32'h0000000e, cp0_epc=32'hBFC00100, if_busy=0 -> flush=1, new_pc=32'hBFC00100, pc_redirect=1.
- Exception 32'h0000000c with if_busy=1 held 3 more cycles:
  - flush=1 for 1 cycle only.
  - Then stall=6'b000011 with pc_redirect=0 for 3 cycles.
  - Then pc_redirect=1 with new_pc=32'h80000180 for 1 cycle, then RUN.
- stallreq_mem=1 and mem_excepttype=32'h00000004 in the same cycle -> flush=1, stall=6'b000000.
- rst during DRAIN -> next cycle stall=0, pc_redirect=0, new_pc=0. With PIPE_CTRL_PERF_EN, stall_cycles=0 and flush_count=0; one later flush -> flush_count=1.

Source files
------------

// File: rtl/pipeline_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl_if
// Bundle of signals between the central pipeline controller and the stages
// it governs.
//   stallreq_if/id/ex/mem : per-stage stall requests (stage -> controller)
//   if_busy               : instruction fetch transaction outstanding
//   mem_excepttype        : MEM-stage exception type, nonzero = exception
//   cp0_epc               : current EPC from CP0
//   stall[5:0]            : bit0 pc .. bit5 wb, 1 = hold (controller -> stages)
//   flush                 : clear all inter-stage registers this cycle
//   pc_redirect, new_pc   : pc register loads new_pc at the next edge
// Modports: master = controller side, slave = pipeline side.
// ---------------------------------------------------------------------------
interface pipeline_ctrl_if;
    logic        stallreq_if;
    logic        stallreq_id;
    logic        stallreq_ex;
    logic        stallreq_mem;
    logic        if_busy;
    logic [31:0] mem_excepttype;
    logic [31:0] cp0_epc;
    logic [5:0]  stall;
    logic        flush;
    logic        pc_redirect;
    logic [31:0] new_pc;

    modport master (
        input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
        input  if_busy, mem_excepttype, cp0_epc,
        output stall, flush, pc_redirect, new_pc
    );

    modport slave (
        output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
        output if_busy, mem_excepttype, cp0_epc,
        input  stall, flush, pc_redirect, new_pc
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
// Central pipeline controller. Arbitrates stage stall requests into the
// stall[5:0] vector, converts MEM-stage exceptions into a single-cycle flush
// plus PC redirect, and defers the redirect (DRAIN state) while an
// instruction fetch is still outstanding on the bus.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   ctrl         : pipeline_ctrl_if.master (requests in, stall/flush/redirect out)
//   stall_cycles : (PIPE_CTRL_PERF_EN only) cycles with stall != 0
//   flush_count  : (PIPE_CTRL_PERF_EN only) cycles with flush == 1
// Optional feature macro: PIPE_CTRL_PERF_EN adds the two perf counters.
// ---------------------------------------------------------------------------
module pipeline_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'h80000180,
    parameter logic [31:0] ERET_CODE  = 32'h0000000e
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef PIPE_CTRL_PERF_EN
    output logic [31:0]           stall_cycles,
    output logic [31:0]           flush_count,
`endif
    pipeline_ctrl_if.master       ctrl
);

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pending_pc;
    logic [31:0] pending_pc_next;
    logic [31:0] exc_target;

    // Exception target: ERET returns to EPC, everything else to the vector.
    assign exc_target = (ctrl.mem_excepttype == ERET_CODE) ? ctrl.cp0_epc : EXC_VECTOR;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            pending_pc <= 32'h0;
        end else begin
            state      <= state_next;
            pending_pc <= pending_pc_next;
        end
    end

    // Outputs are combinational so the stage registers act on them in the
    // same cycle. While rst is high the outputs are held at reset values.
    always_comb begin
        state_next       = state;
        pending_pc_next  = pending_pc;
        ctrl.stall       = 6'b000000;
        ctrl.flush       = 1'b0;
        ctrl.pc_redirect = 1'b0;
        ctrl.new_pc      = 32'h0;

        if (rst) begin
            state_next      = RUN;
            pending_pc_next = 32'h0;
        end else begin
            case (state)
                RUN: begin
                    if (ctrl.mem_excepttype != 32'h0) begin
                        // Exception beats every stall request; a faulting
                        // access has no bus request left to wait for.
                        ctrl.flush  = 1'b1;
                        ctrl.new_pc = exc_target;
                        if (ctrl.if_busy) begin
                            pending_pc_next = exc_target;
                            state_next      = DRAIN;
                        end else begin
                            ctrl.pc_redirect = 1'b1;
                        end
                    end else if (ctrl.stallreq_mem) begin
                        ctrl.stall = 6'b011111;
                    end else if (ctrl.stallreq_ex) begin
                        ctrl.stall = 6'b001111;
                    end else if (ctrl.stallreq_id) begin
                        ctrl.stall = 6'b000111;
                    end else if (ctrl.stallreq_if) begin
                        ctrl.stall = 6'b000011;
                    end
                end
                DRAIN: begin
                    // Pipeline only holds flushed bubbles here, so stage
                    // requests and new exceptions are ignored.
                    ctrl.new_pc = pending_pc;
                    if (ctrl.if_busy) begin
                        ctrl.stall = 6'b000011;
                    end else begin
                        ctrl.pc_redirect = 1'b1;
                        state_next       = RUN;
                    end
                end
                default: begin
                    state_next = RUN;
                end
            endcase
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    // Free-running event counters, wrapping naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= 32'h0;
            flush_count  <= 32'h0;
        end else begin
            if (ctrl.stall != 6'b000000) begin
                stall_cycles <= stall_cycles + 32'h1;
            end
            if (ctrl.flush) begin
                flush_count <= flush_count + 32'h1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_ctrl
// Self-checking bench for pipeline_ctrl: a directed vector table, a reset /
// perf-counter sequence and a randomized phase against a behavioural model.
// ---------------------------------------------------------------------------
module tb_pipeline_ctrl;

    localparam logic [31:0] EXC_VEC = 32'h80000180;
    localparam logic [31:0] ERET    = 32'h0000000e;

    logic clk;
    logic rst;

    pipeline_ctrl_if pif ();

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;
`endif

    pipeline_ctrl #(
        .EXC_VECTOR (EXC_VEC),
        .ERET_CODE  (ERET)
    ) dut (
        .clk          (clk),
        .rst          (rst),
`ifdef PIPE_CTRL_PERF_EN
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count),
`endif
        .ctrl         (pif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Behavioural reference: "is a redirect waiting for the fetch to end,
    // and where to".
    bit          mdl_waiting;
    logic [31:0] mdl_target;
    logic [5:0]  exp_stall;
    logic        exp_flush;
    logic        exp_redir;
    logic [31:0] exp_pc;
    bit          nxt_waiting;
    logic [31:0] nxt_target;
    logic [31:0] mdl_stall_cnt;
    logic [31:0] mdl_flush_cnt;

    typedef struct {
        logic        r;
        logic [3:0]  req;     // {mem, ex, id, if}
        logic        busy;
        logic [31:0] exc;
        logic [31:0] epc;
        bit          chk;
        logic [5:0]  stall;
        logic        flush;
        logic        redir;
        logic [31:0] pc;
    } vec_t;

    vec_t vec [20];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model outputs from the rules: the stall length covers every stage up
    // to and including the highest requesting one, plus the pc register.
    task automatic computeModel();
        int top;
        exp_stall   = '0;
        exp_flush   = 1'b0;
        exp_redir   = 1'b0;
        exp_pc      = '0;
        nxt_waiting = mdl_waiting;
        nxt_target  = mdl_target;
        if (rst) begin
            nxt_waiting = 0;
            nxt_target  = '0;
        end else if (mdl_waiting) begin
            exp_pc = mdl_target;
            if (pif.if_busy) exp_stall = 6'b000011;
            else begin
                exp_redir   = 1'b1;
                nxt_waiting = 0;
            end
        end else if (pif.mem_excepttype != 0) begin
            logic [31:0] t;
            t = (pif.mem_excepttype == ERET) ? pif.cp0_epc : EXC_VEC;
            exp_flush = 1'b1;
            exp_pc    = t;
            if (pif.if_busy) begin
                nxt_waiting = 1;
                nxt_target  = t;
            end else exp_redir = 1'b1;
        end else begin
            top = -1;
            if (pif.stallreq_if)  top = 0;
            if (pif.stallreq_id)  top = 1;
            if (pif.stallreq_ex)  top = 2;
            if (pif.stallreq_mem) top = 3;
            if (top >= 0) exp_stall = 6'((1 << (top + 2)) - 1);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [3:0] req, input logic busy,
                                 input logic [31:0] exc, input logic [31:0] epc);
        rst                = r;
        pif.stallreq_mem   = req[3];
        pif.stallreq_ex    = req[2];
        pif.stallreq_id    = req[1];
        pif.stallreq_if    = req[0];
        pif.if_busy        = busy;
        pif.mem_excepttype = exc;
        pif.cp0_epc        = epc;
        #2;
        computeModel();
    endtask

    // Commit model state on the clock edge, then step past it.
    task automatic advance();
        @(posedge clk);
        mdl_waiting = nxt_waiting;
        mdl_target  = nxt_target;
        if (rst) begin
            mdl_stall_cnt = '0;
            mdl_flush_cnt = '0;
        end else begin
            if (exp_stall != 0) mdl_stall_cnt = mdl_stall_cnt + 32'd1;
            if (exp_flush)      mdl_flush_cnt = mdl_flush_cnt + 32'd1;
        end
        #1;
    endtask

    initial begin
        mdl_waiting   = 0;
        mdl_target    = '0;
        mdl_stall_cnt = '0;
        mdl_flush_cnt = '0;

        //          rst  req     busy exc           epc           chk stall      fl redir pc
        vec[0]  = '{1'b1, 4'b0000, 1'b0, 32'h0,  32'h0,        1, 6'b000000, 1'b0, 1'b0, 32'h0};
        vec[1]  = '{1'b0, 4'b0110, 1'b0, 32'h0,  32'h0,        1, 6'b001111, 1'b0, 1'b0, 32'h0};
        vec[2]  = '{1'b0, 4'b0010, 1'b0, 32'h0,  32'h0,        1, 6'b000111, 1'b0, 1'b0, 32'h0};
        vec[3]  = '{1'b0, 4'b0001, 1'b0, 32'h0,  32'h0,        1, 6'b000011, 1'b0, 1'b0, 32'h0};
        vec[4]  = '{1'b0, 4'b1001, 1'b0, 32'h0,  32'h0,        1, 6'b011111, 1'b0, 1'b0, 32'h0};
        vec[5]  = '{1'b0, 4'b0000, 1'b0, 32'h0,  32'h0,        1, 6'b000000, 1'b0, 1'b0, 32'h0};
        vec[6]  = '{1'b0, 4'b0000, 1'b0, 32'h8,  32'h12345678, 1, 6'b000000, 1'b1, 1'b1, 32'h80000180};
        vec[7]  = '{1'b0, 4'b0000, 1'b0, 32'h0,  32'h0,        1, 6'b000000, 1'b0, 1'b0, 32'h0};
        vec[8]  = '{1'b0, 4'b0000, 1'b0, 32'he,  32'hBFC00100, 1, 6'b000000, 1'b1, 1'b1, 32'hBFC00100};
        vec[9]  = '{1'b0, 4'b0000, 1'b1, 32'hc,  32'hBFC00100, 1, 6'b000000, 1'b1, 1'b0, 32'h80000180};
        vec[10] = '{1'b0, 4'b1111, 1'b1, 32'hc,  32'h0,        1, 6'b000011, 1'b0, 1'b0, 32'h80000180};
        vec[11] = '{1'b0, 4'b1000, 1'b1, 32'he,  32'h0,        1, 6'b000011, 1'b0, 1'b0, 32'h80000180};
        vec[12] = '{1'b0, 4'b0100, 1'b1, 32'h0,  32'h0,        1, 6'b000011, 1'b0, 1'b0, 32'h80000180};
        vec[13] = '{1'b0, 4'b0000, 1'b0, 32'h8,  32'h0,        1, 6'b000000, 1'b0, 1'b1, 32'h80000180};
        vec[14] = '{1'b0, 4'b0000, 1'b0, 32'h0,  32'h0,        1, 6'b000000, 1'b0, 1'b0, 32'h0};
        vec[15] = '{1'b0, 4'b1000, 1'b0, 32'h4,  32'h0,        1, 6'b000000, 1'b1, 1'b1, 32'h80000180};
        vec[16] = '{1'b0, 4'b0000, 1'b1, 32'he,  32'h00400000, 1, 6'b000000, 1'b1, 1'b0, 32'h00400000};
        vec[17] = '{1'b1, 4'b0000, 1'b1, 32'h0,  32'h0,        0, 6'b000000, 1'b0, 1'b0, 32'h0};
        vec[18] = '{1'b0, 4'b0000, 1'b1, 32'h0,  32'h0,        1, 6'b000000, 1'b0, 1'b0, 32'h0};
        vec[19] = '{1'b0, 4'b0000, 1'b0, 32'h0,  32'h0,        1, 6'b000000, 1'b0, 1'b0, 32'h0};

        applyStimulus(1'b1, 4'b0000, 1'b0, 32'h0, 32'h0);
        advance();
        advance();

        $display("[TB] directed vector table");
        for (int i = 0; i < 20; i++) begin
            applyStimulus(vec[i].r, vec[i].req, vec[i].busy, vec[i].exc, vec[i].epc);
            if (vec[i].chk) begin
                checkOutput($sformatf("vec%0d_stall", i), 32'(pif.stall), 32'(vec[i].stall));
                checkOutput($sformatf("vec%0d_flush", i), 32'(pif.flush), 32'(vec[i].flush));
                checkOutput($sformatf("vec%0d_redir", i), 32'(pif.pc_redirect), 32'(vec[i].redir));
                checkOutput($sformatf("vec%0d_newpc", i), pif.new_pc, vec[i].pc);
            end
            advance();
        end

`ifdef PIPE_CTRL_PERF_EN
        $display("[TB] perf counters across reset during drain");
        applyStimulus(1'b0, 4'b0000, 1'b1, 32'hc, 32'h0);
        advance();
        applyStimulus(1'b0, 4'b0000, 1'b1, 32'h0, 32'h0);
        advance();
        applyStimulus(1'b1, 4'b0000, 1'b1, 32'h0, 32'h0);
        advance();
        applyStimulus(1'b0, 4'b0000, 1'b0, 32'h0, 32'h0);
        checkOutput("perf_stall_after_rst", stall_cycles, 32'h0);
        checkOutput("perf_flush_after_rst", flush_count, 32'h0);
        checkOutput("drain_rst_stall", 32'(pif.stall), 32'h0);
        checkOutput("drain_rst_newpc", pif.new_pc, 32'h0);
        advance();
        applyStimulus(1'b0, 4'b0000, 1'b0, 32'h8, 32'h0);
        advance();
        applyStimulus(1'b0, 4'b0000, 1'b0, 32'h0, 32'h0);
        checkOutput("perf_flush_one", flush_count, 32'h1);
        advance();
`endif

        $display("[TB] randomized phase");
        for (int n = 0; n < 400; n++) begin
            logic [31:0] exc;
            int pick;
            pick = int'($urandom_range(0, 9));
            case (pick)
                6:       exc = 32'h8;
                7:       exc = ERET;
                8:       exc = 32'hc;
                9:       exc = $urandom | 32'h1;
                default: exc = 32'h0;
            endcase
            applyStimulus(($urandom_range(0, 39) == 0), 4'($urandom), 1'($urandom),
                          exc, $urandom);
            checkOutput("rnd_stall", 32'(pif.stall), 32'(exp_stall));
            checkOutput("rnd_flush", 32'(pif.flush), 32'(exp_flush));
            checkOutput("rnd_redir", 32'(pif.pc_redirect), 32'(exp_redir));
            checkOutput("rnd_newpc", pif.new_pc, exp_pc);
`ifdef PIPE_CTRL_PERF_EN
            checkOutput("rnd_stall_cycles", stall_cycles, mdl_stall_cnt);
            checkOutput("rnd_flush_count", flush_count, mdl_flush_cnt);
`endif
            advance();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
